// File: rtl/mult_arbiter_if.sv
// Request/result bundle between the particle cluster and the shared multiplier.
// The master side issues operations; the slave side is the arbiter.
interface mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_flat;
  logic [N_REQ*WIDTH-1:0] b_flat;
  logic [N_REQ-1:0]       grant;
  logic [WIDTH-1:0]       res;
  logic [N_REQ-1:0]       res_valid;
  logic [15:0]            op_count;

  modport master (
    output req, a_flat, b_flat,
    input  grant, res, res_valid, op_count
  );

  modport slave (
    input  req, a_flat, b_flat,
    output grant, res, res_valid, op_count
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin shared signed multiplier: one accept per cycle, two-stage pipeline,
// result = (a*b) >>> SHIFT truncated to WIDTH and tagged one-hot to its requester.
module mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int SHIFT = 4
) (
  input logic           clk,
  input logic           reset,
  mult_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef logic [PTR_W-1:0] idx_t;

  idx_t             ptr;
  idx_t             grant_idx;
  idx_t             ptr_next;
  logic             any_req;
  logic             accept;
  logic [N_REQ-1:0] grant_vec;

  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];

  logic                    s1_valid;
  logic [N_REQ-1:0]        s1_tag;
  logic signed [WIDTH-1:0] s1_a;
  logic signed [WIDTH-1:0] s1_b;

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] q;
  logic                      unused_q_hi;

  logic [WIDTH-1:0] res_q;
  logic [N_REQ-1:0] res_valid_q;
  logic [15:0]      op_count_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = bus.a_flat[g*WIDTH +: WIDTH];
    assign b_arr[g] = bus.b_flat[g*WIDTH +: WIDTH];
  end

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    // NOTE: every combinational output is given a default first, so no path can infer a latch.
    any_req   = 1'b0;
    grant_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[idx_t'((int'(ptr) + k) % N_REQ)]) begin
        any_req   = 1'b1;
        grant_idx = idx_t'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  assign accept   = any_req & ~reset;
  assign ptr_next = (grant_idx == idx_t'(N_REQ - 1)) ? '0 : grant_idx + idx_t'(1);

  always_comb begin
    grant_vec = '0;
    if (accept) grant_vec[grant_idx] = 1'b1;
  end

  assign bus.grant = grant_vec;

  always_ff @(posedge clk) begin
    // NOTE: all sequential state is written with non-blocking assignments only.
    if (reset) begin
      ptr         <= '0;
      s1_valid    <= 1'b0;
      s1_tag      <= '0;
      res_q       <= '0;
      res_valid_q <= '0;
      op_count_q  <= '0;
    end else begin
      if (accept) begin
        ptr        <= ptr_next;
        op_count_q <= op_count_q + 16'd1;
      end
      s1_valid    <= accept;
      s1_tag      <= grant_vec;
      res_valid_q <= s1_valid ? s1_tag : '0;
      if (s1_valid) res_q <= q[WIDTH-1:0];
    end
  end

  // NOTE: operand registers are left unreset; s1_valid alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a <= a_arr[grant_idx];
      s1_b <= b_arr[grant_idx];
    end
  end

  // Full-width signed product, floor-shifted, then wrapped to WIDTH bits.
  assign prod        = s1_a * s1_b;
  assign q           = prod >>> SHIFT;
  assign unused_q_hi = ^q[2*WIDTH-1:WIDTH];

  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.op_count  = op_count_q;

  a_grant_onehot : assert property (@(posedge clk) $onehot0(bus.grant));
  a_valid_onehot : assert property (@(posedge clk) $onehot0(bus.res_valid));

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one signed WIDTH x WIDTH multiplier among N_REQ particle/spring-update requesters, so each particle no longer needs its own `(multa*multb) >>> 4` multiplier.
- Round-robin arbitration, one operation accepted per cycle.
- Two-stage pipeline; each result returns tagged by a one-hot valid to the requester that issued it.
- Sits between the particle cluster and a single DSP-class multiplier in the physics top level.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 16, operand and result width, signed two's complement
SHIFT, 4, arithmetic right shift applied to the full product (fixed-point scaling)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester operation request; level, held until granted
a_flat  input  N_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH]
b_flat  input  N_REQ*WIDTH  operand B, packed the same way
grant  output  N_REQ  one-hot or zero, combinational; accept = req[i] & grant[i] at posedge
res  output  WIDTH  registered result of the oldest completed operation
res_valid  output  N_REQ  one-hot or zero, registered; marks which requester owns res this cycle
op_count  output  16  count of accepted operations, wraps at 0xFFFF -> 0

Behaviour:
- Reset values: grant=0, res=0, res_valid=0, op_count=0, priority pointer ptr=0, both pipeline valid bits=0.
- grant is forced to 0 while reset is high.
- Arbitration (combinational): scan indices ptr, ptr+1, ..., ptr+N_REQ-1 (mod N_REQ). Grant the first i with req[i]=1. No req -> grant=0.
- Pointer update (at posedge): if any grant, ptr <= (granted index + 1) mod N_REQ; otherwise ptr is unchanged.
- Handshake:
  - A requester keeps req and its operands stable until it sees grant.
  - Every cycle with req[i] & grant[i] is one new operation; a held req issues back-to-back operations whenever granted again.
  - Deasserting req before grant cancels the request with no side effect.
- Pipeline:
  - Edge T (accept): stage-1 registers capture A, B, the one-hot tag and valid.
  - Edge T+1: stage 2 computes P = A*B as a 2*WIDTH signed product, then Q = P >>> SHIFT (arithmetic, floor toward -inf). res <= Q[WIDTH-1:0] (truncating wrap, no saturation); res_valid <= tag.
  - res/res_valid are visible in the cycle after edge T+1; latency is 2 clocks from accept.
- Throughput: one accept per cycle; no stall and no backpressure on the result side. The consumer must take res in the single cycle res_valid is high.
- res holds its last value when res_valid=0.
- op_count increments by 1 on every accept edge.
- Reset mid-operation: in-flight stage-1/stage-2 operations are discarded and no res_valid is produced for them. Everything returns to reset values on the next edge after reset is sampled high.
- At most one bit of grant and of res_valid is ever set.
- An accept and a result delivery in the same cycle are independent and both occur.

Test Plan:
- Reset, then req=0001, a0=5, b0=-32 -> grant=0001 in the same cycle; exactly 2 clocks later res=0xFFF6 (-10), res_valid=0001 for one cycle; op_count=1.
- req=1011 held for 4 cycles after reset, distinct operands per requester -> grant sequence 0001, 0010, 1000, 0001; res_valid follows the same sequence 2 cycles later, each with the matching products.
- Overflow: a=0x7FFF, b=0x7FFF -> res=0xF000. Floor rounding: a=-1, b=1 -> res=0xFFFF. Zero: a=0, b=-7 -> res=0x0000.
- req=0100 accepted, then reset asserted 1 cycle later -> no res_valid ever appears; grant=0 during reset; ptr=0 afterwards, so req=1111 is then granted to requester 0 first.
- Requester 2 raises req, then drops it before being granted (others hold priority) -> no result for requester 2; op_count excludes it.
- Continuous req=1111 for 65536 accepts -> op_count wraps to 0; results stream one per cycle with no gaps.
